// File: rtl/clk_in_monitor_pkg.sv
// Shared types and helpers for the slow-clock input monitor.
// Holds the monitor state encoding and the phase-length tolerance test.
package clk_in_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_e;

    // Inclusive window [nominal - tol, nominal + tol] on a measured phase length.
    function automatic logic len_in_range(input int len, input int nominal, input int tol);
        return (len >= nominal - tol) && (len <= nominal + tol);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous slow clock.
// Adds a history flop and registered single-cycle rise/fall strobes.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d_async;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign level = s2;

endmodule

// File: rtl/clk_in_monitor.sv
// Slow-clock monitor: edge strobes, high/low phase measurement and a
// lock/loss health indication against the nominal input frequency.
module clk_in_monitor
    import clk_in_monitor_pkg::*;
#(
    parameter int SYS_CLK      = 50000000,
    parameter int CLK_IN       = 1000000,
    parameter int NOMINAL_HALF = SYS_CLK / (2 * CLK_IN),
    parameter int TOL          = 2,
    parameter int LOCK_COUNT   = 4,
    parameter int TIMEOUT      = 4 * NOMINAL_HALF,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clk_in,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             locked,
    output logic             loss_stb,
    output logic [7:0]       loss_cnt
);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  STALL_AT  = CNT_W'(TIMEOUT - 1);
    localparam int                GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

    logic              sync_level_unused;
    logic              sync_rise;
    logic              sync_fall;
    logic              any_stb;
    logic              stall;
    logic              in_range;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  len;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] next_good;
    logic              loss_event;
    mon_state_e        state;
    mon_state_e        next_state;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (clk_in),
        .level   (sync_level_unused),
        .rise    (sync_rise),
        .fall    (sync_fall)
    );

    assign rise_stb = sync_rise & enable;
    assign fall_stb = sync_fall & enable;
    assign any_stb  = rise_stb | fall_stb;

    assign len      = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + CNT_W'(1);
    assign in_range = len_in_range(32'(len), NOMINAL_HALF, TOL);
    // An edge landing on the timeout cycle takes precedence over the stall.
    assign stall    = enable && (hcnt == STALL_AT) && !any_stb;

    // The counter restarts on a stall too, so a static input keeps producing
    // a stall every TIMEOUT cycles (LOCKED -> ACQUIRE -> IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
        end else if (enable) begin
            if (any_stb || stall) begin
                hcnt <= '0;
            end else if (hcnt != CNT_MAX) begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_len <= '0;
            low_len  <= '0;
        end else begin
            if (fall_stb) begin
                high_len <= len;
            end
            if (rise_stb) begin
                low_len <= len;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_good  = good_cnt;
        loss_event = 1'b0;
        if (!enable) begin
            next_state = IDLE;
            next_good  = '0;
        end else begin
            case (state)
                IDLE: begin
                    // First edge only starts a measurement; its phase is partial.
                    if (any_stb) begin
                        next_state = ACQUIRE;
                        next_good  = '0;
                    end
                end
                ACQUIRE: begin
                    if (any_stb) begin
                        if (!in_range) begin
                            next_good = '0;
                        end else if (good_cnt == GOOD_LAST) begin
                            next_state = LOCKED;
                            next_good  = '0;
                        end else begin
                            next_good = good_cnt + GOOD_W'(1);
                        end
                    end else if (stall) begin
                        next_state = IDLE;
                        next_good  = '0;
                    end
                end
                LOCKED: begin
                    if ((any_stb && !in_range) || stall) begin
                        next_state = ACQUIRE;
                        next_good  = '0;
                        loss_event = 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_good  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            good_cnt <= '0;
            locked   <= 1'b0;
            loss_stb <= 1'b0;
            loss_cnt <= '0;
        end else begin
            state    <= next_state;
            good_cnt <= next_good;
            locked   <= (next_state == LOCKED);
            loss_stb <= loss_event;
            if (loss_event && (loss_cnt != 8'hFF)) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_clk_in_monitor.sv
// Randomized bench for clk_in_monitor against an edge-event reference model
// that predicts strobes, phase lengths and lock/loss behaviour per cycle.
module tb_clk_in_monitor;

    localparam int NOMINAL_HALF = 25;
    localparam int TOL          = 2;
    localparam int LOCK_COUNT   = 4;
    localparam int TIMEOUT      = 100;
    localparam int SYNC_LAT     = 3;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clk_in;
    logic       rise_stb;
    logic       fall_stb;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic       locked;
    logic       loss_stb;
    logic [7:0] loss_cnt;

    clk_in_monitor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clk_in   (clk_in),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .high_len (high_len),
        .low_len  (low_len),
        .locked   (locked),
        .loss_stb (loss_stb),
        .loss_cnt (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int at;
        bit rise;
    } ev_t;

    ev_t evq[$];
    ev_t ev_now;
    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;

    // Reference model: strobes expected this cycle, cycles since last edge,
    // and the expected registered outputs.
    bit  cur_r, cur_f;
    int  m_since, m_good, m_loss_cnt, m_high, m_low;
    bit  m_seen, m_lock, m_loss;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        evq.delete();
        cur_r = 0; cur_f = 0;
        m_since = 0; m_good = 0; m_loss_cnt = 0; m_high = 0; m_low = 0;
        m_seen = 0; m_lock = 0; m_loss = 0;
    endtask

    task automatic model_step();
        int len;
        bit stb, stall, ok, lost;
        stb  = cur_r | cur_f;
        lost = 0;
        if (enable) begin
            len   = (m_since + 1 > 255) ? 255 : m_since + 1;
            stall = (m_since == TIMEOUT - 1) && !stb;
            ok    = (len >= NOMINAL_HALF - TOL) && (len <= NOMINAL_HALF + TOL);
            if (cur_f) m_high = len;
            if (cur_r) m_low  = len;
            if (stb) begin
                if (!m_seen) begin
                    m_seen = 1;
                    m_good = 0;
                end else if (m_lock) begin
                    if (!ok) lost = 1;
                end else if (ok) begin
                    m_good++;
                    if (m_good == LOCK_COUNT) begin
                        m_lock = 1;
                        m_good = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end else if (stall) begin
                if (m_lock) lost = 1;
                else m_seen = 0;
            end
            m_since = (stb || stall) ? 0 : ((m_since >= 255) ? 255 : m_since + 1);
        end else begin
            m_seen = 0;
            m_lock = 0;
            m_good = 0;
        end
        if (lost) begin
            m_lock = 0;
            m_good = 0;
            if (m_loss_cnt < 255) m_loss_cnt++;
        end
        m_loss = lost;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            cyc++;
            #1;
            cur_r = 0;
            cur_f = 0;
            if (rst_n) begin
                if (evq.size() > 0 && evq[0].at == cyc) begin
                    ev_now = evq.pop_front();
                    cur_r  = enable && ev_now.rise;
                    cur_f  = enable && !ev_now.rise;
                end
                chk("rise_stb", int'(rise_stb), int'(cur_r));
                chk("fall_stb", int'(fall_stb), int'(cur_f));
                chk("high_len", int'(high_len), m_high);
                chk("low_len",  int'(low_len),  m_low);
                chk("locked",   int'(locked),   int'(m_lock));
                chk("loss_stb", int'(loss_stb), int'(m_loss));
                chk("loss_cnt", int'(loss_cnt), m_loss_cnt);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic phase(input int n);
        clk_in = ~clk_in;
        evq.push_back('{cyc + SYNC_LAT, clk_in});
        step(n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rise"},   int'(rise_stb), 0);
        chk({tag, "_fall"},   int'(fall_stb), 0);
        chk({tag, "_high"},   int'(high_len), 0);
        chk({tag, "_low"},    int'(low_len),  0);
        chk({tag, "_locked"}, int'(locked),   0);
        chk({tag, "_loss"},   int'(loss_stb), 0);
        chk({tag, "_lcnt"},   int'(loss_cnt), 0);
    endtask

    initial begin
        int r;
        rst_n  = 1'b0;
        enable = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        step(10);

        // Nominal 25/25 input
        repeat (8) phase(25);
        chk("nom_locked", int'(locked), 1);
        chk("nom_high", int'(high_len), 25);
        chk("nom_low", int'(low_len), 25);

        // Tolerance edges 23/27 keep lock, 22 drops it
        phase(23);
        phase(27);
        phase(22);
        phase(25);
        chk("tol_locked", int'(locked), 0);
        chk("tol_lcnt", int'(loss_cnt), 1);
        repeat (5) phase(25);
        chk("relock", int'(locked), 1);

        // Static input: loss after TIMEOUT, idle after another TIMEOUT
        phase(250);
        chk("stall_locked", int'(locked), 0);
        chk("stall_lcnt", int'(loss_cnt), 2);
        repeat (6) phase(25);
        chk("stall_relock", int'(locked), 1);

        // Edge exactly on the timeout cycle
        phase(TIMEOUT);
        phase(25);
        chk("coinc_len", int'(high_len == 8'd100 || low_len == 8'd100), 1);
        chk("coinc_lcnt", int'(loss_cnt), 3);
        chk("coinc_locked", int'(locked), 0);
        repeat (5) phase(25);

        // Enable drop while locked
        enable = 1'b0;
        repeat (2) phase(25);
        chk("dis_locked", int'(locked), 0);
        chk("dis_lcnt", int'(loss_cnt), 3);
        enable = 1'b1;
        repeat (6) phase(25);
        chk("en_relock", int'(locked), 1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("areset");
        @(posedge clk);
        #2;
        clk_in = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(5);
        repeat (6) phase(25);
        chk("rst_relock", int'(locked), 1);

        // Random phase lengths with occasional enable drops
        repeat (300) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                enable = 1'b0;
                phase($urandom_range(10, 40));
                enable = 1'b1;
            end else if (r < 70) begin
                phase($urandom_range(23, 27));
            end else if (r < 85) begin
                phase($urandom_range(5, 45));
            end else if (r < 95) begin
                phase($urandom_range(97, 103));
            end else begin
                phase(150);
            end
        end
        step(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
